// File: rtl/local_mem_pkg.sv
// Shared defaults and response entry type for the Vortex-to-local-memory bridge.
package local_mem_pkg;
  localparam int ADDR_W_DEF     = 26;
  localparam int DATA_W_DEF     = 512;
  localparam int TAG_W_DEF      = 8;
  localparam int RD_LATENCY_DEF = 2;
  localparam int RSP_DEPTH_DEF  = 4;

  typedef struct packed {
    logic [TAG_W_DEF-1:0]  tag;
    logic [DATA_W_DEF-1:0] data;
  } rsp_entry_t;
endpackage

// File: rtl/local_mem_bridge_if.sv
// Vortex memory request/response bus; master is the core side, slave the bridge.
interface local_mem_bridge_if
  import local_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
);
  logic                mem_req_valid;
  logic                mem_req_rw;
  logic [DATA_W/8-1:0] mem_req_byteen;
  logic [ADDR_W-1:0]   mem_req_addr;
  logic [DATA_W-1:0]   mem_req_data;
  logic [TAG_W-1:0]    mem_req_tag;
  logic                mem_req_ready;
  logic                mem_rsp_valid;
  logic [DATA_W-1:0]   mem_rsp_data;
  logic [TAG_W-1:0]    mem_rsp_tag;
  logic                mem_rsp_ready;

  modport master (
    output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    output mem_rsp_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    input  mem_rsp_ready
  );
endinterface

// File: rtl/local_mem_rsp_fifo.sv
// Response FIFO: extra pointer bit separates full from empty; head is zero when empty.
module local_mem_rsp_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  entry_t din,
  input  logic   pop,
  output entry_t dout,
  output logic   valid,
  output logic   drop
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr, rptr;
  entry_t      mem [DEPTH];
  logic        empty, full, wr_en, rd_en;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rd_en = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign wr_en = push & (~full | rd_en);
  assign drop  = push & ~wr_en;
  assign valid = ~empty;
  assign dout  = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/local_mem_bridge.sv
// Bridges Vortex memory requests onto a fixed-latency local memory; reads return
// in order through a credit-protected response FIFO.
module local_mem_bridge
  import local_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int TAG_W      = TAG_W_DEF,
  parameter int RD_LATENCY = RD_LATENCY_DEF,
  parameter int RSP_DEPTH  = RSP_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  local_mem_bridge_if.slave   bus,
  output logic                lm_ren,
  output logic                lm_wen,
  output logic [ADDR_W-1:0]   lm_addr,
  output logic [DATA_W-1:0]   lm_wdata,
  output logic [DATA_W/8-1:0] lm_byteen,
  input  logic [DATA_W-1:0]   lm_rdata,
  output logic                busy,
  output logic                rsp_overflow
);
  localparam int CW = $clog2(RSP_DEPTH) + 1;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic                             up;
  logic [CW-1:0]                    credits;
  logic [RD_LATENCY:1]              vld_pipe;
  logic [RD_LATENCY:1][TAG_W-1:0]   tag_pipe;
  logic                             acc, rd_acc, pop, drop;
  entry_t                           head;

  // Credits cover FIFO slots plus reads in flight, so a retire always finds room.
  assign bus.mem_req_ready = up & (bus.mem_req_rw | (credits != '0));
  assign acc    = bus.mem_req_valid & bus.mem_req_ready;
  assign rd_acc = acc & ~bus.mem_req_rw;
  assign pop    = bus.mem_rsp_valid & bus.mem_rsp_ready;

  assign lm_ren    = rd_acc;
  assign lm_wen    = acc & bus.mem_req_rw;
  assign lm_addr   = bus.mem_req_addr;
  assign lm_wdata  = bus.mem_req_data;
  assign lm_byteen = bus.mem_req_byteen;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      up           <= 1'b0;
      credits      <= CW'(RSP_DEPTH);
      vld_pipe     <= '0;
      tag_pipe     <= '0;
      rsp_overflow <= 1'b0;
    end else begin
      up          <= 1'b1;
      credits     <= credits - CW'(rd_acc) + CW'(pop) + CW'(drop);
      vld_pipe[1] <= rd_acc;
      tag_pipe[1] <= bus.mem_req_tag;
      for (int i = 2; i <= RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
      if (drop) rsp_overflow <= 1'b1;
    end
  end

  local_mem_rsp_fifo #(
    .DEPTH   (RSP_DEPTH),
    .entry_t (entry_t)
  ) u_rsp_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (vld_pipe[RD_LATENCY]),
    .din   ('{tag: tag_pipe[RD_LATENCY], data: lm_rdata}),
    .pop   (bus.mem_rsp_ready),
    .dout  (head),
    .valid (bus.mem_rsp_valid),
    .drop  (drop)
  );

  assign bus.mem_rsp_data = head.data;
  assign bus.mem_rsp_tag  = head.tag;
  assign busy = (|vld_pipe) | bus.mem_rsp_valid;
endmodule

// File: tb/tb_local_mem_bridge.sv
// Directed bench for local_mem_bridge: scoreboard of expected read responses
// checked by an independent monitor, plus a behavioural local memory.
module tb_local_mem_bridge;
  localparam int AW = 26, DW = 512, TW = 8, BW = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          lm_ren, lm_wen, busy, rsp_overflow;
  logic [AW-1:0] lm_addr;
  logic [DW-1:0] lm_wdata, lm_rdata, rd_s1, rd_s2;
  logic [BW-1:0] lm_byteen;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] wmem[int];
  int            checks = 0, errors = 0, cyc = 0, rd_acc_count = 0;
  int            last_acc = 0, wait_cycles = 0;

  local_mem_bridge_if #(.ADDR_W(AW), .DATA_W(DW), .TAG_W(TW)) bus ();

  local_mem_bridge dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .lm_ren       (lm_ren),
    .lm_wen       (lm_wen),
    .lm_addr      (lm_addr),
    .lm_wdata     (lm_wdata),
    .lm_byteen    (lm_byteen),
    .lm_rdata     (lm_rdata),
    .busy         (busy),
    .rsp_overflow (rsp_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Contents of never-written locations.
  function automatic logic [DW-1:0] pat(input int a);
    logic [DW-1:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = 32'(a) * 32'h0100_0193 + 32'(i);
    return r;
  endfunction

  // Local memory: byte-enabled writes, reads valid two cycles after lm_ren.
  always @(posedge clk) begin
    logic [DW-1:0] cur;
    if (lm_wen) begin
      cur = wmem.exists(int'(lm_addr)) ? wmem[int'(lm_addr)] : pat(int'(lm_addr));
      for (int b = 0; b < BW; b++) if (lm_byteen[b]) cur[b*8 +: 8] = lm_wdata[b*8 +: 8];
      wmem[int'(lm_addr)] = cur;
    end
    if (lm_ren) rd_s1 <= wmem.exists(int'(lm_addr)) ? wmem[int'(lm_addr)] : pat(int'(lm_addr));
    else        rd_s1 <= 'x;
    rd_s2 <= rd_s1;
  end
  assign lm_rdata = rd_s2;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every response handshake must match the oldest expected read.
  always @(negedge clk) begin
    if (bus.mem_req_valid && bus.mem_req_ready && !bus.mem_req_rw) rd_acc_count++;
    if (reset && bus.mem_rsp_valid && bus.mem_rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: got tag %0h expected no response", bus.mem_rsp_tag);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_tag", DW'(bus.mem_rsp_tag), DW'(e.tag));
        chk("rsp_data", bus.mem_rsp_data, e.data);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic rw, input int a, input logic [DW-1:0] d,
                       input logic [BW-1:0] be, input int t, input logic [DW-1:0] exp_d);
    int n = 0;
    bus.mem_req_valid = 1'b1; bus.mem_req_rw = rw; bus.mem_req_addr = AW'(a);
    bus.mem_req_data = d; bus.mem_req_byteen = be; bus.mem_req_tag = TW'(t);
    @(negedge clk);
    while (!bus.mem_req_ready && n < 50) begin n++; @(negedge clk); end
    wait_cycles = n;
    if (!bus.mem_req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got ready 0 expected 1 (addr %0h)", a);
    end else begin
      last_acc = cyc;
      chk("lm_addr", DW'(lm_addr), DW'(a));
      chk(rw ? "lm_wen" : "lm_ren", DW'({lm_wen, lm_ren}), rw ? DW'(2'b10) : DW'(2'b01));
      if (rw) chk("lm_wdata", lm_wdata, d);
      else exp_q.push_back('{tag: TW'(t), data: exp_d});
    end
    @(posedge clk); #1;
    bus.mem_req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin n++; @(posedge clk); end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    #1;
    @(negedge clk);
    chk("idle_busy", DW'(busy), '0);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string ph);
    chk({ph, "_req_ready"}, DW'(bus.mem_req_ready), '0);
    chk({ph, "_rsp_valid"}, DW'(bus.mem_rsp_valid), '0);
    chk({ph, "_rsp_data"}, bus.mem_rsp_data, '0);
    chk({ph, "_rsp_tag"}, DW'(bus.mem_rsp_tag), '0);
    chk({ph, "_lm_en"}, DW'({lm_ren, lm_wen}), '0);
    chk({ph, "_busy"}, DW'(busy), '0);
    chk({ph, "_overflow"}, DW'(rsp_overflow), '0);
  endtask

  initial begin
    int base, lat, n;
    reset = 1'b0;
    bus.mem_req_valid = 1'b1; bus.mem_req_rw = 1'b0; bus.mem_req_addr = '0;
    bus.mem_req_data = '0; bus.mem_req_byteen = '1; bus.mem_req_tag = '0;
    bus.mem_rsp_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    bus.mem_req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1 chk("ready_after_release", DW'(bus.mem_req_ready), '0);
    @(posedge clk); #1;
    chk("ready_first_rise", DW'(bus.mem_req_ready), DW'(1));

    // Single write then read with latency check.
    issue(1'b1, 'h10, DW'(32'h6F00_8004), '1, 0, '0);
    issue(1'b0, 'h10, '0, '1, 3, DW'(32'h6F00_8004));
    n = 0;
    @(negedge clk);
    while (!bus.mem_rsp_valid && n < 20) begin n++; @(negedge clk); end
    lat = cyc - last_acc;
    chk("rd_latency", DW'(lat), DW'(3));
    @(posedge clk); #1;
    drain();

    // Byte enables: only byte 0 of the second write lands.
    issue(1'b1, 'h20, '1, '1, 0, '0);
    issue(1'b1, 'h20, '0, BW'(1), 0, '0);
    issue(1'b0, 'h20, '0, '1, 7, ~DW'(8'hFF));
    drain();

    // Backpressure: four credits, then writes still pass at zero credit.
    bus.mem_rsp_ready = 1'b0;
    base = rd_acc_count;
    for (int i = 0; i < 4; i++) issue(1'b0, i, '0, '1, 10 + i, pat(i));
    bus.mem_req_valid = 1'b1; bus.mem_req_rw = 1'b0;
    bus.mem_req_addr = AW'(4); bus.mem_req_tag = TW'(14);
    repeat (6) @(negedge clk);
    chk("bp_ready_low", DW'(bus.mem_req_ready), '0);
    chk("bp_accepts", DW'(rd_acc_count - base), DW'(4));
    chk("bp_head_tag", DW'({bus.mem_rsp_valid, bus.mem_rsp_tag}), DW'({1'b1, 8'd10}));
    @(posedge clk); #1;
    bus.mem_req_valid = 1'b0;
    issue(1'b1, 'h30, DW'(32'hA5A5_5A5A), '1, 0, '0);
    chk("zero_credit_write_wait", DW'(wait_cycles), '0);
    bus.mem_rsp_ready = 1'b1;
    issue(1'b0, 4, '0, '1, 14, pat(4));
    issue(1'b0, 5, '0, '1, 15, pat(5));
    chk("bp_total_accepts", DW'(rd_acc_count - base), DW'(6));
    drain();

    // Streaming: one read accepted every cycle.
    base = rd_acc_count;
    bus.mem_req_valid = 1'b1; bus.mem_req_rw = 1'b0; bus.mem_req_byteen = '1;
    for (int i = 0; i < 32; i++) begin
      bus.mem_req_addr = AW'('h40 + i); bus.mem_req_tag = TW'(i);
      @(negedge clk);
      chk("stream_ready", DW'(bus.mem_req_ready), DW'(1));
      if (bus.mem_req_ready) exp_q.push_back('{tag: TW'(i), data: pat('h40 + i)});
      @(posedge clk); #1;
    end
    bus.mem_req_valid = 1'b0;
    chk("stream_accepts", DW'(rd_acc_count - base), DW'(32));
    drain();
    chk("stream_overflow", DW'(rsp_overflow), '0);

    // Reset with two reads in flight.
    issue(1'b0, 'h50, '0, '1, 'h21, pat('h50));
    issue(1'b0, 'h51, '0, '1, 'h22, pat('h51));
    chk("midburst_busy", DW'(busy), DW'(1));
    reset = 1'b0;
    exp_q.delete();
    bus.mem_req_valid = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    bus.mem_req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.mem_rsp_valid) n++;
    end
    chk("post_reset_rsp_count", DW'(n), '0);
    chk("post_reset_busy", DW'(busy), '0);
    chk("post_reset_ready", DW'(bus.mem_req_ready), DW'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/local_mem_bridge.md
LOCAL_MEM_BRIDGE -- requirements
Module: local_mem_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 26; Vortex memory-bus word-address width.
REQ-002 SHALL have parameter DATA_W, default 512; memory-bus data width, a multiple of 8.
REQ-003 SHALL have parameter TAG_W, default 8; request/response tag width.
REQ-004 SHALL have parameter RD_LATENCY, default 2; local-memory read latency in cycles, legal range 1..7.
REQ-005 SHALL have parameter RSP_DEPTH, default 4; response FIFO entries, a power of two ≥2.
REQ-006 SHALL have port clk  input  1  rising-edge clock.
REQ-007 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have Vortex request ports: mem_req_valid in 1; mem_req_rw in 1 (1=write); mem_req_byteen in DATA_W/8; mem_req_addr in ADDR_W; mem_req_data in DATA_W; mem_req_tag in TAG_W; mem_req_ready out 1.
REQ-009 SHALL have Vortex response ports: mem_rsp_valid out 1; mem_rsp_data out DATA_W; mem_rsp_tag out TAG_W; mem_rsp_ready in 1.
REQ-010 SHALL have local-memory ports: lm_ren out 1; lm_wen out 1; lm_addr out ADDR_W; lm_wdata out DATA_W; lm_byteen out DATA_W/8; lm_rdata in DATA_W, valid exactly RD_LATENCY cycles after an lm_ren cycle.
REQ-011 SHALL have status ports: busy out 1 (reads in flight or FIFO non-empty); rsp_overflow out 1 (sticky error).

Function
REQ-012 A request SHALL be accepted on a cycle with mem_req_valid & mem_req_ready high.
REQ-013 An accepted write SHALL drive lm_wen=1 with addr/data/byteen in that cycle, combinationally, and SHALL generate no response.
REQ-014 An accepted read SHALL drive lm_ren=1 and lm_addr that cycle, push its tag into a RD_LATENCY-deep tag/valid shift pipeline, and retire into the response FIFO with lm_rdata exactly RD_LATENCY cycles later.
REQ-015 Credit counter: credits = RSP_DEPTH − (FIFO count + reads in flight); width clog2(RSP_DEPTH)+1.
REQ-016 mem_req_ready SHALL be 1 when credits > 0, or when mem_req_rw=1 (writes never consume credit).
REQ-017 A FIFO pop (mem_rsp_valid & mem_rsp_ready) SHALL return one credit the same cycle; simultaneous read accept and pop SHALL leave credits unchanged.
REQ-018 mem_rsp_valid SHALL be FIFO non-empty; mem_rsp_data/tag SHALL be the FIFO head, held stable until popped.
REQ-019 Responses SHALL return in request order; tags pass through unmodified.
REQ-020 Pipeline retire into a full FIFO SHALL be impossible by credits; if it occurs, rsp_overflow SHALL set and remain set until reset, and the entry SHALL be dropped.
REQ-021 FIFO pointers SHALL wrap modulo RSP_DEPTH; full and empty SHALL be distinguished by an extra pointer bit.
REQ-022 Minimum read-to-response latency SHALL be RD_LATENCY+1 cycles (FIFO registered output).
REQ-023 Sustained throughput with mem_rsp_ready=1 SHALL be one read per cycle when RSP_DEPTH ≥ RD_LATENCY+1.
REQ-024 Pipeline and FIFO SHALL advance unconditionally; backpressure SHALL be applied only via mem_req_ready.

Reset
REQ-025 While reset=0: mem_req_ready=0, mem_rsp_valid=0, mem_rsp_data=0, mem_rsp_tag=0, lm_ren=0, lm_wen=0, busy=0, rsp_overflow=0, credits=RSP_DEPTH, pipeline valids=0, FIFO pointers=0.
REQ-026 Reset asserted mid-operation SHALL discard in-flight reads and queued responses; no response SHALL appear after deassertion.
REQ-027 mem_req_ready SHALL first rise the cycle after reset deasserts.

Structure
REQ-028 Shared package local_mem_pkg SHALL hold the parameter defaults and the rsp_entry_t struct {tag, data}.
REQ-029 The response FIFO SHALL be sub-module local_mem_rsp_fifo (parameters DEPTH, entry type).

Verification
REQ-030 Single read: write addr 0x10 data 0x6F008004 (byteen all ones), then read 0x10 tag 3 -> rsp tag 3 data 0x6F008004 RD_LATENCY+1 cycles after accept.
REQ-031 Byte enables: write 0xFFFFFFFF, then 0x00000000 with byteen 0x1 -> readback 0xFFFFFF00 in the low word.
REQ-032 Backpressure: mem_rsp_ready=0, issue 6 reads (RSP_DEPTH=4) -> exactly 4 accepted, ready low; raise rsp_ready -> remaining 2 accepted, 6 in-order tags.
REQ-033 Streaming: 32 back-to-back reads, rsp_ready=1 -> one accept per cycle, tags 0..31 in order, rsp_overflow=0.
REQ-034 Writes at zero credit: FIFO full, issue write -> accepted same cycle, lm_wen=1.
REQ-035 Reset mid-burst: assert reset with 2 reads in flight -> all outputs at reset values, no responses after release, busy=0.
